// File: rtl/rename_regfile.sv
// rtl/rename_regfile.sv - architectural register file with rename tags, commit write-back and dispatch bypass
module rename_regfile #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int REG_W      = 5,
    parameter int TAG_W      = 4,
    parameter int NUM_COMMIT = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        disp_valid,
    input  logic [REG_W-1:0]            disp_rs1,
    input  logic [REG_W-1:0]            disp_rs2,
    input  logic [REG_W-1:0]            disp_rd,
    input  logic [TAG_W-1:0]            disp_tag,
    input  logic [NUM_COMMIT-1:0]       cmt_valid,
    input  logic [NUM_COMMIT*REG_W-1:0] cmt_rd,
    input  logic [NUM_COMMIT*TAG_W-1:0] cmt_tag,
    input  logic [NUM_COMMIT*XLEN-1:0]  cmt_data,
    output logic                        out_valid,
    output logic [XLEN-1:0]             out_v1,
    output logic [XLEN-1:0]             out_v2,
    output logic [TAG_W-1:0]            out_q1,
    output logic [TAG_W-1:0]            out_q2,
    output logic                        out_r1,
    output logic                        out_r2,
    output logic [REG_W-1:0]            out_rd,
    output logic [TAG_W-1:0]            out_tag
);

    logic [XLEN-1:0]  value   [NREG];
    logic             busy    [NREG];
    logic [TAG_W-1:0] tag     [NREG];

    logic [XLEN-1:0]  value_n [NREG];
    logic             busy_n  [NREG];
    logic [TAG_W-1:0] tag_n   [NREG];

    logic             dispatch;

    logic [REG_W-1:0] src     [2];
    logic             src_r   [2];
    logic [XLEN-1:0]  src_v   [2];
    logic [TAG_W-1:0] src_q   [2];

    assign dispatch = disp_valid && !flush;
    assign src[0]   = disp_rs1;
    assign src[1]   = disp_rs2;

    // Commit ports are applied in ascending order so the youngest port overwrites
    // both the value and the busy-clear decision on a shared destination.
    always_comb begin
        value_n = value;
        busy_n  = busy;
        tag_n   = tag;
        for (int k = 0; k < NUM_COMMIT; k++) begin
            if (cmt_valid[k] && (cmt_rd[k*REG_W +: REG_W] != '0)) begin
                value_n[cmt_rd[k*REG_W +: REG_W]] = cmt_data[k*XLEN +: XLEN];
                if (busy[cmt_rd[k*REG_W +: REG_W]] &&
                    (tag[cmt_rd[k*REG_W +: REG_W]] == cmt_tag[k*TAG_W +: TAG_W]))
                    busy_n[cmt_rd[k*REG_W +: REG_W]] = 1'b0;
                else
                    busy_n[cmt_rd[k*REG_W +: REG_W]] = busy[cmt_rd[k*REG_W +: REG_W]];
            end
        end
        if (flush) begin
            for (int i = 0; i < NREG; i++)
                busy_n[i] = 1'b0;
        end else if (dispatch && (disp_rd != '0)) begin
            busy_n[disp_rd] = 1'b1;
            tag_n[disp_rd]  = disp_tag;
        end
    end

    // Sources observe the pre-rename mapping, with same-cycle commit results bypassed.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_r[s] = 1'b1;
            src_v[s] = '0;
            src_q[s] = '0;
            if (src[s] != '0) begin
                src_v[s] = value[src[s]];
                if (busy[src[s]]) begin
                    src_r[s] = 1'b0;
                    src_q[s] = tag[src[s]];
                    for (int k = 0; k < NUM_COMMIT; k++) begin
                        if (cmt_valid[k] && (cmt_tag[k*TAG_W +: TAG_W] == tag[src[s]])) begin
                            src_r[s] = 1'b1;
                            src_v[s] = cmt_data[k*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                value[i] <= '0;
                busy[i]  <= 1'b0;
                tag[i]   <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                value[i] <= value_n[i];
                busy[i]  <= busy_n[i];
                tag[i]   <= tag_n[i];
            end
            value[0] <= '0;
            busy[0]  <= 1'b0;
            tag[0]   <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_v1    <= '0;
            out_v2    <= '0;
            out_q1    <= '0;
            out_q2    <= '0;
            out_r1    <= 1'b0;
            out_r2    <= 1'b0;
            out_rd    <= '0;
            out_tag   <= '0;
        end else if (dispatch) begin
            out_valid <= 1'b1;
            out_v1    <= src_v[0];
            out_v2    <= src_v[1];
            out_q1    <= src_q[0];
            out_q2    <= src_q[1];
            out_r1    <= src_r[0];
            out_r2    <= src_r[1];
            out_rd    <= disp_rd;
            out_tag   <= disp_tag;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// tb/tb_rename_regfile.sv - directed-vector bench for rename_regfile
module tb_rename_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        disp_valid;
    logic [4:0]  disp_rs1;
    logic [4:0]  disp_rs2;
    logic [4:0]  disp_rd;
    logic [3:0]  disp_tag;
    logic [1:0]  cmt_valid;
    logic [9:0]  cmt_rd;
    logic [7:0]  cmt_tag;
    logic [63:0] cmt_data;
    logic        out_valid;
    logic [31:0] out_v1;
    logic [31:0] out_v2;
    logic [3:0]  out_q1;
    logic [3:0]  out_q2;
    logic        out_r1;
    logic        out_r2;
    logic [4:0]  out_rd;
    logic [3:0]  out_tag;

    int n_vec = 0;
    int n_bad = 0;

    rename_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .disp_valid (disp_valid),
        .disp_rs1   (disp_rs1),
        .disp_rs2   (disp_rs2),
        .disp_rd    (disp_rd),
        .disp_tag   (disp_tag),
        .cmt_valid  (cmt_valid),
        .cmt_rd     (cmt_rd),
        .cmt_tag    (cmt_tag),
        .cmt_data   (cmt_data),
        .out_valid  (out_valid),
        .out_v1     (out_v1),
        .out_v2     (out_v2),
        .out_q1     (out_q1),
        .out_q2     (out_q2),
        .out_r1     (out_r1),
        .out_r2     (out_r2),
        .out_rd     (out_rd),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        flush      = 1'b0;
        disp_valid = 1'b0;
        disp_rs1   = '0;
        disp_rs2   = '0;
        disp_rd    = '0;
        disp_tag   = '0;
        cmt_valid  = '0;
        cmt_rd     = '0;
        cmt_tag    = '0;
        cmt_data   = '0;
    endtask

    task automatic disp(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [3:0] t);
        disp_valid = 1'b1;
        disp_rs1   = rs1;
        disp_rs2   = rs2;
        disp_rd    = rd;
        disp_tag   = t;
    endtask

    task automatic cmt(input int port, input logic [4:0] rd, input logic [3:0] t,
                       input logic [31:0] d);
        cmt_valid[port]          = 1'b1;
        cmt_rd[port*5 +: 5]      = rd;
        cmt_tag[port*4 +: 4]     = t;
        cmt_data[port*32 +: 32]  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        disp(5'd3, 5'd4, 5'd7, 4'd2);
        step();
        step();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_v1", out_v1, 32'd0);
        check("rst_r1", {31'b0, out_r1}, 32'd0);
        check("rst_tag", {28'b0, out_tag}, 32'd0);
        rst = 1'b0;

        // 1: plain read after reset
        disp(5'd3, 5'd0, 5'd0, 4'd0);
        step();
        check("t1_valid", {31'b0, out_valid}, 32'd1);
        check("t1_r1", {31'b0, out_r1}, 32'd1);
        check("t1_v1", out_v1, 32'd0);
        check("t1_r2", {31'b0, out_r2}, 32'd1);
        check("t1_v2", out_v2, 32'd0);
        step();
        check("t1_idle_valid", {31'b0, out_valid}, 32'd0);
        check("t1_idle_hold_r1", {31'b0, out_r1}, 32'd1);

        // 2: rename then commit
        disp(5'd0, 5'd0, 5'd5, 4'd7);
        step();
        check("t2_echo_rd", {27'b0, out_rd}, 32'd5);
        check("t2_echo_tag", {28'b0, out_tag}, 32'd7);
        disp(5'd5, 5'd5, 5'd0, 4'd1);
        step();
        check("t2_r1_busy", {31'b0, out_r1}, 32'd0);
        check("t2_q1", {28'b0, out_q1}, 32'd7);
        check("t2_q2", {28'b0, out_q2}, 32'd7);
        cmt(0, 5'd5, 4'd7, 32'hDEAD);
        step();
        disp(5'd5, 5'd0, 5'd0, 4'd1);
        step();
        check("t2_r1_done", {31'b0, out_r1}, 32'd1);
        check("t2_v1", out_v1, 32'hDEAD);

        // 3: same-cycle bypass
        disp(5'd0, 5'd0, 5'd5, 4'd7);
        step();
        cmt(0, 5'd5, 4'd7, 32'h11);
        disp(5'd5, 5'd0, 5'd0, 4'd1);
        step();
        check("t3_byp_r1", {31'b0, out_r1}, 32'd1);
        check("t3_byp_v1", out_v1, 32'h11);
        disp(5'd5, 5'd0, 5'd0, 4'd1);
        step();
        check("t3_after_r1", {31'b0, out_r1}, 32'd1);
        check("t3_after_v1", out_v1, 32'h11);

        // 4: stale commit keeps newer rename
        disp(5'd0, 5'd0, 5'd5, 4'd2);
        step();
        disp(5'd0, 5'd0, 5'd5, 4'd3);
        step();
        cmt(0, 5'd5, 4'd2, 32'h22);
        step();
        disp(5'd5, 5'd0, 5'd0, 4'd1);
        step();
        check("t4_r1", {31'b0, out_r1}, 32'd0);
        check("t4_q1", {28'b0, out_q1}, 32'd3);
        check("t4_v1", out_v1, 32'h22);
        cmt(1, 5'd5, 4'd3, 32'h33);
        step();

        // source equal to destination sees the old mapping
        disp(5'd5, 5'd0, 5'd5, 4'd4);
        step();
        check("rsrd_r1", {31'b0, out_r1}, 32'd1);
        check("rsrd_v1", out_v1, 32'h33);
        disp(5'd5, 5'd0, 5'd0, 4'd1);
        step();
        check("rsrd_next_r1", {31'b0, out_r1}, 32'd0);
        check("rsrd_next_q1", {28'b0, out_q1}, 32'd4);

        // 5: two ports, same rd; x0 write ignored
        cmt(0, 5'd6, 4'd0, 32'hA);
        cmt(1, 5'd6, 4'd0, 32'hB);
        step();
        cmt(0, 5'd0, 4'd0, 32'hFFFF);
        step();
        disp(5'd6, 5'd0, 5'd0, 4'd1);
        step();
        check("t5_v1", out_v1, 32'hB);
        check("t5_x0_v2", out_v2, 32'd0);

        // 6: flush with commit and ignored dispatch
        disp(5'd0, 5'd0, 5'd4, 4'd9);
        step();
        flush = 1'b1;
        cmt(0, 5'd8, 4'd0, 32'h5);
        disp(5'd1, 5'd0, 5'd9, 4'd1);
        step();
        check("t6_flush_valid", {31'b0, out_valid}, 32'd0);
        disp(5'd4, 5'd8, 5'd0, 4'd1);
        step();
        check("t6_x4_r", {31'b0, out_r1}, 32'd1);
        check("t6_x8_r", {31'b0, out_r2}, 32'd1);
        check("t6_x8_v", out_v2, 32'h5);
        disp(5'd9, 5'd5, 5'd0, 4'd1);
        step();
        check("t6_x9_r", {31'b0, out_r1}, 32'd1);
        check("t6_x5_r", {31'b0, out_r2}, 32'd1);

        // rename overrides same-cycle busy-clear on the same rd
        disp(5'd0, 5'd0, 5'd10, 4'd5);
        step();
        cmt(0, 5'd10, 4'd5, 32'h77);
        disp(5'd10, 5'd0, 5'd10, 4'd6);
        step();
        check("ovr_byp_r1", {31'b0, out_r1}, 32'd1);
        check("ovr_byp_v1", out_v1, 32'h77);
        disp(5'd10, 5'd0, 5'd0, 4'd1);
        step();
        check("ovr_r1", {31'b0, out_r1}, 32'd0);
        check("ovr_q1", {28'b0, out_q1}, 32'd6);
        check("ovr_v1", out_v1, 32'h77);

        // reset in the middle of dispatch
        rst = 1'b1;
        disp(5'd6, 5'd10, 5'd0, 4'd1);
        step();
        check("mrst_valid", {31'b0, out_valid}, 32'd0);
        check("mrst_v1", out_v1, 32'd0);
        rst = 1'b0;
        disp(5'd6, 5'd10, 5'd0, 4'd1);
        step();
        check("mrst_x6_v", out_v1, 32'd0);
        check("mrst_x10_r", {31'b0, out_r2}, 32'd1);
        check("mrst_x10_v", out_v2, 32'd0);
        check("mrst_x10_q", {28'b0, out_q2}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
